// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared FFT constants and the bit-reverse index helper.
// Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int C_FFT_N_DEFAULT = 3;
    localparam int C_FFT_MAX_N     = 16;
    localparam int C_FFT_IDX_W     = 4;

    // Reverses the low n bits of k; the loop bound is fixed so it always terminates.
    function automatic logic [C_FFT_MAX_N-1:0] fft_bitrev(
        input logic [C_FFT_MAX_N-1:0] k,
        input int                     n
    );
        logic [C_FFT_MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < C_FFT_MAX_N; i++) begin
            if (i < n) begin
                r[C_FFT_IDX_W'(i)] = k[C_FFT_IDX_W'(n - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_bank.sv
`default_nettype none
// ============================================================================
// Module   : reorder_bank
// Brief    : L x DW register array, one synchronous write, one async read.
// Revision : 1.0
// ============================================================================
module reorder_bank #(
    parameter int N  = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [N-1:0]  waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [N-1:0]  raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [1<<N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : bitrev_reorder
// Brief    : Ping-pong bit-reversed to natural order frame reorder buffer.
// Revision : 1.0
// ============================================================================
module bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N  = C_FFT_N_DEFAULT,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_last
);

    localparam logic [N-1:0] C_LAST = {N{1'b1}};

    logic                   wbank_q, wbank_d;
    logic [N-1:0]           wcnt_q,  wcnt_d;
    logic                   rbank_q, rbank_d;
    logic [N-1:0]           rcnt_q,  rcnt_d;
    logic [1:0]             full_q,  full_d;

    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_wr_done;
    logic                   w_rd_done;
    logic [C_FFT_MAX_N-1:0] w_wcnt_ext;
    logic [N-1:0]           w_waddr;
    logic [DW-1:0]          w_rdata [2];

    assign in_ready   = !full_q[wbank_q];
    assign out_valid  = full_q[rbank_q];
    assign out_last   = out_valid && (rcnt_q == C_LAST);
    assign out_data   = w_rdata[rbank_q];

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_wr_done  = w_in_fire && (wcnt_q == C_LAST);
    assign w_rd_done  = w_out_fire && (rcnt_q == C_LAST);

    always_comb begin
        w_wcnt_ext         = '0;
        w_wcnt_ext[N-1:0]  = wcnt_q;
    end

    assign w_waddr = N'(fft_bitrev(w_wcnt_ext, N));

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            reorder_bank #(
                .N  (N),
                .DW (DW)
            ) u_bank (
                .clk     (clk),
                .we_i    (w_in_fire && (wbank_q == 1'(b))),
                .waddr_i (w_waddr),
                .wdata_i (in_data),
                .raddr_i (rcnt_q),
                .rdata_o (w_rdata[b])
            );
        end
    endgenerate

    // Write fills only a non-full bank and read drains only a full one, so the
    // set and clear below can never target the same flag in one cycle.
    always_comb begin
        wbank_d = wbank_q;
        wcnt_d  = wcnt_q;
        rbank_d = rbank_q;
        rcnt_d  = rcnt_q;
        full_d  = full_q;
        if (w_in_fire) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        if (w_wr_done) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = !wbank_q;
        end
        if (w_out_fire) begin
            rcnt_d = rcnt_q + 1'b1;
        end
        if (w_rd_done) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = !rbank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_q <= 1'b0;
            wcnt_q  <= '0;
            rbank_q <= 1'b0;
            rcnt_q  <= '0;
            full_q  <= '0;
        end else begin
            wbank_q <= wbank_d;
            wcnt_q  <= wcnt_d;
            rbank_q <= rbank_d;
            rcnt_q  <= rcnt_d;
            full_q  <= full_d;
        end
    end

endmodule
`default_nettype wire
